smg_scan_module: RTL and testbench

Six-digit multiplexed seven-segment driver. Sits directly downstream of the BCD counter/control stage. It consumes its 24-bit packed-BCD `Number_Sig` and time-multiplexes it onto the board's common-anode display: one digit per slot, active-low segments, active-low digit selects. The input is snapshotted once per frame so a displayed frame never mixes two values. Optional leading-zero blanking is provided, along with a short anti-ghosting dead time at each digit change.

---
 rtl/smg_scan_module.sv | 126 ++++++++++++
 tb/tb_smg_scan_module.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/smg_scan_module.sv
`default_nettype none
// ============================================================================
// Module   : smg_scan_module
// Brief    : Six-digit multiplexed seven-segment driver for a common-anode
//            display. Active-low segments, active-low one-hot digit selects,
//            per-frame input snapshot, leading-zero blanking and a short
//            dead time at each digit change.
// Revision : 1.0 - initial release
// ============================================================================
module smg_scan_module #(
    parameter logic [15:0] T1MS   = 16'd49_999,  // slot length minus 1
    parameter logic [15:0] TBLANK = 16'd499      // dead time minus 1, < T1MS
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic [23:0] Number_Sig,
    input  logic        Blank_En,
    output logic [7:0]  SMG_Data,
    output logic [5:0]  Scan_Sig,
    output logic        Frame_Done
);

    localparam logic [2:0] C_LAST_DIGIT = 3'd5;
    localparam logic [7:0] C_SEG_OFF    = 8'hFF;
    localparam logic [5:0] C_SCAN_OFF   = 6'b111111;

    logic [15:0] r_c1;
    logic [2:0]  r_idx;
    logic [23:0] r_number;

    logic        w_tick;
    logic        w_frame;
    logic [5:0]  w_lead_zero;
    logic [3:0]  w_nib;
    logic        w_blank;
    logic [7:0]  w_seg;

    assign w_tick  = (r_c1 == T1MS);
    assign w_frame = w_tick && (r_idx == C_LAST_DIGIT);

    // Slot counter: 0..T1MS, then wraps; the terminal cycle is the tick
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_c1 <= 16'd0;
        end else if (w_tick) begin
            r_c1 <= 16'd0;
        end else begin
            r_c1 <= r_c1 + 16'd1;
        end
    end

    // Digit index: advance per tick; 5 and any stray 6/7 return to digit 0
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_idx <= 3'd0;
        end else if (w_tick) begin
            r_idx <= (r_idx >= C_LAST_DIGIT) ? 3'd0 : r_idx + 3'd1;
        end
    end

    // Frame snapshot and one-cycle frame pulse on the 5->0 tick
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_number   <= 24'd0;
            Frame_Done <= 1'b0;
        end else begin
            Frame_Done <= w_frame;
            if (w_frame) begin
                r_number <= Number_Sig;
            end
        end
    end

    // w_lead_zero[k]: nibbles k..5 of the snapshot are all zero
    generate
        for (genvar k = 0; k < 6; k++) begin : g_lead_zero
            assign w_lead_zero[k] = (r_number[23:4*k] == {(24-4*k){1'b0}});
        end
    endgenerate

    // Pick the nibble of the digit being scanned and decide blanking
    always_comb begin
        w_nib   = 4'd0;
        w_blank = 1'b1;
        case (r_idx)
            3'd0: begin w_nib = r_number[3:0];   w_blank = 1'b0; end
            3'd1: begin w_nib = r_number[7:4];   w_blank = Blank_En & w_lead_zero[1]; end
            3'd2: begin w_nib = r_number[11:8];  w_blank = Blank_En & w_lead_zero[2]; end
            3'd3: begin w_nib = r_number[15:12]; w_blank = Blank_En & w_lead_zero[3]; end
            3'd4: begin w_nib = r_number[19:16]; w_blank = Blank_En & w_lead_zero[4]; end
            3'd5: begin w_nib = r_number[23:20]; w_blank = Blank_En & w_lead_zero[5]; end
            default: begin w_nib = 4'd0;         w_blank = 1'b1; end
        endcase
    end

    // BCD to active-low segments {dp,g,f,e,d,c,b,a}; illegal codes show a dash
    always_comb begin
        w_seg = 8'hBF;
        case (w_nib)
            4'd0: w_seg = 8'hC0;
            4'd1: w_seg = 8'hF9;
            4'd2: w_seg = 8'hA4;
            4'd3: w_seg = 8'hB0;
            4'd4: w_seg = 8'h99;
            4'd5: w_seg = 8'h92;
            4'd6: w_seg = 8'h82;
            4'd7: w_seg = 8'hF8;
            4'd8: w_seg = 8'h80;
            4'd9: w_seg = 8'h90;
            default: w_seg = 8'hBF;
        endcase
    end

    // Registered display outputs; selects held off during each slot's dead time
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            SMG_Data <= C_SEG_OFF;
            Scan_Sig <= C_SCAN_OFF;
        end else begin
            SMG_Data <= w_blank ? C_SEG_OFF : w_seg;
            Scan_Sig <= (r_c1 <= TBLANK) ? C_SCAN_OFF : ~(6'b000001 << r_idx);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_smg_scan_module.sv
`default_nettype none
// ============================================================================
// Module   : tb_smg_scan_module
// Brief    : Self-checking bench for smg_scan_module (T1MS=9, TBLANK=1).
//            A cycle-count reference model predicts every output each cycle;
//            scenario tasks add fixed expectations at notable points.
// Revision : 1.0 - initial release
// ============================================================================
module tb_smg_scan_module;

    localparam int SLOT  = 10;
    localparam int DEAD  = 2;
    localparam int FRAME = 6 * SLOT;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic [23:0] Number_Sig = 24'd0;
    logic        Blank_En = 1'b0;
    logic [7:0]  SMG_Data;
    logic [5:0]  Scan_Sig;
    logic        Frame_Done;

    int n_assert = 0;
    int n_fail   = 0;

    smg_scan_module #(
        .T1MS   (16'd9),
        .TBLANK (16'd1)
    ) dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .Number_Sig (Number_Sig),
        .Blank_En   (Blank_En),
        .SMG_Data   (SMG_Data),
        .Scan_Sig   (Scan_Sig),
        .Frame_Done (Frame_Done)
    );

    always #5 CLK = ~CLK;

    logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    // Expected pattern for digit k of a snapshot
    function automatic logic [7:0] exp_digit(input logic [23:0] snap, input int k, input logic blank);
        logic [23:0] upper;
        int          nib;
        upper = snap >> (4 * k);
        nib   = int'(upper[3:0]);
        if (blank && k != 0 && upper == 24'd0) return 8'hFF;
        if (nib > 9) return 8'hBF;
        return seg_tab[nib];
    endfunction

    // Reference model: position in the scan is derived from cycles since reset
    int          m_cyc;
    int          m_slot;
    logic [23:0] m_snap;
    logic [7:0]  m_smg;
    logic [5:0]  m_scan;
    logic        m_fd;

    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            m_cyc  = 0;
            m_snap = 24'd0;
            m_smg  = 8'hFF;
            m_scan = 6'h3F;
            m_fd   = 1'b0;
        end else begin
            m_slot = (m_cyc / SLOT) % 6;
            m_smg  = exp_digit(m_snap, m_slot, Blank_En);
            m_scan = ((m_cyc % SLOT) < DEAD) ? 6'h3F : (6'h3F ^ (6'd1 << m_slot));
            m_fd   = ((m_cyc % FRAME) == FRAME - 1);
            if (m_fd) m_snap = Number_Sig;
            m_cyc++;
        end
    end

    task automatic do_reset(input logic [23:0] num, input logic blank);
        @(negedge CLK);
        RSTn = 1'b0;
        Number_Sig = num;
        Blank_En = blank;
        repeat (2) @(negedge CLK);
        RSTn = 1'b1;
    endtask

    task automatic test_reset();
        logic [5:0] walk [6];
        walk = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
        @(negedge CLK);
        RSTn = 1'b0;
        repeat (3) @(negedge CLK);
        n_assert++; if (SMG_Data !== 8'hFF) begin n_fail++; $display("FAIL reset_smg got=%h exp=ff", SMG_Data); end
        n_assert++; if (Scan_Sig !== 6'h3F) begin n_fail++; $display("FAIL reset_scan got=%h exp=3f", Scan_Sig); end
        n_assert++; if (Frame_Done !== 1'b0) begin n_fail++; $display("FAIL reset_fd got=%b exp=0", Frame_Done); end
        RSTn = 1'b1;
        for (int j = 1; j <= FRAME; j++) begin
            @(negedge CLK);
            n_assert++; if (SMG_Data !== m_smg) begin n_fail++; $display("FAIL walk_smg j=%0d got=%h exp=%h", j, SMG_Data, m_smg); end
            n_assert++; if (Scan_Sig !== m_scan) begin n_fail++; $display("FAIL walk_scan j=%0d got=%h exp=%h", j, Scan_Sig, m_scan); end
            n_assert++; if (Frame_Done !== m_fd) begin n_fail++; $display("FAIL walk_fd j=%0d got=%b exp=%b", j, Frame_Done, m_fd); end
            if ((j - 1) % SLOT < DEAD) begin
                n_assert++; if (Scan_Sig !== 6'h3F) begin n_fail++; $display("FAIL walk_dead j=%0d got=%h exp=3f", j, Scan_Sig); end
            end else if ((j - 1) % SLOT == DEAD) begin
                n_assert++; if (Scan_Sig !== walk[(j - 1) / SLOT]) begin n_fail++; $display("FAIL walk_sel j=%0d got=%h exp=%h", j, Scan_Sig, walk[(j - 1) / SLOT]); end
            end
        end
    endtask

    task automatic test_snapshot_midframe();
        logic [7:0] tab [6];
        int first_fd;
        tab = '{8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
        first_fd = -1;
        do_reset(24'h123456, 1'b0);
        for (int j = 1; j <= 3 * FRAME; j++) begin
            @(negedge CLK);
            n_assert++; if (SMG_Data !== m_smg) begin n_fail++; $display("FAIL snap_smg j=%0d got=%h exp=%h", j, SMG_Data, m_smg); end
            n_assert++; if (Scan_Sig !== m_scan) begin n_fail++; $display("FAIL snap_scan j=%0d got=%h exp=%h", j, Scan_Sig, m_scan); end
            n_assert++; if (Frame_Done !== m_fd) begin n_fail++; $display("FAIL snap_fd j=%0d got=%b exp=%b", j, Frame_Done, m_fd); end
            if (Frame_Done === 1'b1 && first_fd < 0) first_fd = j;
            if (j > FRAME && j <= 2 * FRAME && (j - 1) % SLOT == 4) begin
                n_assert++; if (SMG_Data !== tab[((j - 1) / SLOT) % 6]) begin n_fail++; $display("FAIL snap_digit j=%0d got=%h exp=%h", j, SMG_Data, tab[((j - 1) / SLOT) % 6]); end
            end
            if (j > 2 * FRAME && (j - 1) % SLOT == 4) begin
                n_assert++; if (SMG_Data !== 8'hC0) begin n_fail++; $display("FAIL mid_zero j=%0d got=%h exp=c0", j, SMG_Data); end
            end
            if (j == FRAME + 25) Number_Sig = 24'h000000;
        end
        n_assert++; if (first_fd != FRAME) begin n_fail++; $display("FAIL first_frame_done got=%0d exp=%0d", first_fd, FRAME); end
    endtask

    task automatic test_blanking();
        logic [7:0] ta [6];
        logic [7:0] tb [6];
        logic [7:0] tc [6];
        logic [7:0] e;
        ta = '{8'hF8, 8'hC0, 8'h92, 8'hFF, 8'hFF, 8'hFF};
        tb = '{8'hF8, 8'hC0, 8'h92, 8'hC0, 8'hC0, 8'hC0};
        tc = '{8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        do_reset(24'h000507, 1'b1);
        for (int j = 1; j <= 4 * FRAME; j++) begin
            @(negedge CLK);
            n_assert++; if (SMG_Data !== m_smg) begin n_fail++; $display("FAIL blank_smg j=%0d got=%h exp=%h", j, SMG_Data, m_smg); end
            n_assert++; if (Scan_Sig !== m_scan) begin n_fail++; $display("FAIL blank_scan j=%0d got=%h exp=%h", j, Scan_Sig, m_scan); end
            if (j > FRAME && (j - 1) % SLOT == 4) begin
                if (j <= 2 * FRAME)      e = ta[((j - 1) / SLOT) % 6];
                else if (j <= 3 * FRAME) e = tb[((j - 1) / SLOT) % 6];
                else                     e = tc[((j - 1) / SLOT) % 6];
                n_assert++; if (SMG_Data !== e) begin n_fail++; $display("FAIL blank_digit j=%0d got=%h exp=%h", j, SMG_Data, e); end
            end
            if (j == 2 * FRAME) begin Blank_En = 1'b0; Number_Sig = 24'h000000; end
            if (j == 3 * FRAME) Blank_En = 1'b1;
        end
    endtask

    task automatic test_illegal();
        logic [7:0] ta [6];
        logic [7:0] tb [6];
        logic [7:0] e;
        ta = '{8'hBF, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
        tb = '{8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hBF};
        do_reset(24'h00000A, 1'b0);
        for (int j = 1; j <= 3 * FRAME; j++) begin
            @(negedge CLK);
            n_assert++; if (SMG_Data !== m_smg) begin n_fail++; $display("FAIL illegal_smg j=%0d got=%h exp=%h", j, SMG_Data, m_smg); end
            n_assert++; if (Scan_Sig !== m_scan) begin n_fail++; $display("FAIL illegal_scan j=%0d got=%h exp=%h", j, Scan_Sig, m_scan); end
            if (j > FRAME && (j - 1) % SLOT == 4) begin
                e = (j <= 2 * FRAME) ? ta[((j - 1) / SLOT) % 6] : tb[((j - 1) / SLOT) % 6];
                n_assert++; if (SMG_Data !== e) begin n_fail++; $display("FAIL illegal_digit j=%0d got=%h exp=%h", j, SMG_Data, e); end
            end
            if (j == 100) Number_Sig = 24'hA00000;
            if (j == 2 * FRAME) Blank_En = 1'b1;
        end
    endtask

    task automatic test_async_reset();
        do_reset(24'h123456, 1'b0);
        for (int j = 1; j <= 35; j++) begin
            @(negedge CLK);
            n_assert++; if (SMG_Data !== m_smg) begin n_fail++; $display("FAIL ar_pre_smg j=%0d got=%h exp=%h", j, SMG_Data, m_smg); end
            n_assert++; if (Scan_Sig !== m_scan) begin n_fail++; $display("FAIL ar_pre_scan j=%0d got=%h exp=%h", j, Scan_Sig, m_scan); end
        end
        n_assert++; if (Scan_Sig !== 6'h37) begin n_fail++; $display("FAIL ar_digit3 got=%h exp=37", Scan_Sig); end
        RSTn = 1'b0;
        #1;
        n_assert++; if (SMG_Data !== 8'hFF) begin n_fail++; $display("FAIL ar_smg got=%h exp=ff", SMG_Data); end
        n_assert++; if (Scan_Sig !== 6'h3F) begin n_fail++; $display("FAIL ar_scan got=%h exp=3f", Scan_Sig); end
        n_assert++; if (Frame_Done !== 1'b0) begin n_fail++; $display("FAIL ar_fd got=%b exp=0", Frame_Done); end
        @(negedge CLK);
        RSTn = 1'b1;
        for (int j = 1; j <= FRAME + SLOT; j++) begin
            @(negedge CLK);
            n_assert++; if (SMG_Data !== m_smg) begin n_fail++; $display("FAIL ar_post_smg j=%0d got=%h exp=%h", j, SMG_Data, m_smg); end
            n_assert++; if (Scan_Sig !== m_scan) begin n_fail++; $display("FAIL ar_post_scan j=%0d got=%h exp=%h", j, Scan_Sig, m_scan); end
            if (j == 3) begin
                n_assert++; if (Scan_Sig !== 6'h3E) begin n_fail++; $display("FAIL ar_restart_sel got=%h exp=3e", Scan_Sig); end
            end
            if (j == 5) begin
                n_assert++; if (SMG_Data !== 8'hC0) begin n_fail++; $display("FAIL ar_snap_zero got=%h exp=c0", SMG_Data); end
            end
            if (j == FRAME + 5) begin
                n_assert++; if (SMG_Data !== 8'h82) begin n_fail++; $display("FAIL ar_new_snap got=%h exp=82", SMG_Data); end
            end
        end
    endtask

    task automatic test_random();
        int          hold;
        int          nd;
        logic [23:0] v;
        hold = 0;
        do_reset(24'h000000, 1'b0);
        for (int j = 1; j <= 2000; j++) begin
            @(negedge CLK);
            n_assert++; if (SMG_Data !== m_smg) begin n_fail++; $display("FAIL rnd_smg j=%0d got=%h exp=%h", j, SMG_Data, m_smg); end
            n_assert++; if (Scan_Sig !== m_scan) begin n_fail++; $display("FAIL rnd_scan j=%0d got=%h exp=%h", j, Scan_Sig, m_scan); end
            n_assert++; if (Frame_Done !== m_fd) begin n_fail++; $display("FAIL rnd_fd j=%0d got=%b exp=%b", j, Frame_Done, m_fd); end
            if (!RSTn) RSTn = 1'b1;
            else if ($urandom_range(0, 599) == 0) RSTn = 1'b0;
            if ($urandom_range(0, 19) == 0) Blank_En = ~Blank_En;
            if (hold == 0) begin
                nd = $urandom_range(0, 6);
                v  = 24'd0;
                for (int d = 0; d < nd; d++) begin
                    v[4*d +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                              : 4'($urandom_range(0, 9));
                end
                Number_Sig = v;
                hold = $urandom_range(1, 40);
            end else begin
                hold--;
            end
        end
    endtask

    initial begin
        test_reset();
        test_snapshot_midframe();
        test_blanking();
        test_illegal();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
